clk_gen_prog: RTL

Runtime-programmable clock generator that divides clk_source by any integer DIV ≥ 2 with a programmable high time.
- Successor to the fixed 2^16 divider: parametrised counter width, programmable duty cycle, glitch-free enable/disable, and a valid/ready configuration port.
- New settings are applied only at period boundaries.
- Sits between the board oscillator and slow peripheral clock domains (UART baud, LED scan, sensor sampling).

---
 rtl/clk_gen_pkg.sv | 38 +++
 rtl/clk_gen_cfg_shadow.sv | 56 +++++
 rtl/clk_gen_prog.sv | 138 +++++++++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_pkg
// Shared types and helpers for the programmable clock generator.
//   state_t   : generator state (IDLE, RUN, DRAIN), 2 bits
//   MIN_DIV   : smallest legal divisor
//   sanitise  : clamps a requested (div, high) pair so the output always toggles
// The helper works on SAN_W-bit values; callers zero-extend their CNT_W-bit
// fields into it and truncate the result back (CNT_W must not exceed SAN_W).
// -----------------------------------------------------------------------------
package clk_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int MIN_DIV = 2;
   localparam int SAN_W   = 32;

   typedef struct packed {
      logic [SAN_W-1:0] div;
      logic [SAN_W-1:0] high;
   } cfg_pair_t;

   // The high-time clamp uses the already-clamped divisor.
   function automatic cfg_pair_t sanitise(input logic [SAN_W-1:0] div,
                                          input logic [SAN_W-1:0] high);
      cfg_pair_t r;
      r.div  = (div < SAN_W'(MIN_DIV)) ? SAN_W'(MIN_DIV) : div;
      r.high = (high == '0) ? SAN_W'(1) : high;
      if (r.high >= r.div) begin
         r.high = r.div - SAN_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/clk_gen_cfg_shadow.sv
// -----------------------------------------------------------------------------
// clk_gen_cfg_shadow
// Configuration port of the clock generator: valid/ready handshake, sanitising
// of the offered values, and a one-deep shadow register that is released to the
// active settings only when the top asserts 'apply' (a period boundary or IDLE).
// Ports:
//   clk_source, rst       : clock, asynchronous active-high reset
//   cfg_div, cfg_high     : requested period / high time
//   cfg_valid, cfg_ready  : handshake; ready is low while a shadow is pending
//   apply                 : top indicates the active regs may be updated now
//   load                  : shadow is being copied to active on this edge
//   shadow_div/high       : sanitised captured values
// -----------------------------------------------------------------------------
module clk_gen_cfg_shadow
   import clk_gen_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_source,
   input  logic             rst,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             apply,
   output logic             load,
   output logic [CNT_W-1:0] shadow_div,
   output logic [CNT_W-1:0] shadow_high
);

   logic      pending;
   logic      accept;
   cfg_pair_t san;

   assign san       = sanitise(SAN_W'(cfg_div), SAN_W'(cfg_high));
   assign cfg_ready = !pending;
   assign accept    = cfg_valid && cfg_ready;
   // accept needs !pending and load needs pending, so a value captured on a
   // boundary edge is never released on that same edge.
   assign load      = apply && pending;

   always_ff @(posedge clk_source or posedge rst) begin
      if (rst) begin
         pending     <= 1'b0;
         shadow_div  <= '0;
         shadow_high <= '0;
      end else if (accept) begin
         pending     <= 1'b1;
         shadow_div  <= CNT_W'(san.div);
         shadow_high <= CNT_W'(san.high);
      end else if (load) begin
         pending     <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_gen_prog.sv
// -----------------------------------------------------------------------------
// clk_gen_prog
// Runtime-programmable clock generator: divides clk_source by div_a (>= 2) with
// clk_out high for the first high_a cycles of each period. Enable/disable is
// glitch-free (a stopping clock always finishes its current period) and new
// settings take effect only at period boundaries.
// Ports:
//   clk_source            : source clock, everything on its rising edge
//   rst                   : asynchronous active-high reset
//   en                    : run request (level)
//   cfg_div, cfg_high     : requested period / high time in source cycles
//   cfg_valid, cfg_ready  : configuration handshake
//   clk_out               : generated clock (registered)
//   running               : high while in RUN or DRAIN
//   period_stb            : only with CLKGEN_PERIOD_STROBE_EN defined; one-cycle
//                           pulse coincident with clk_out rising at period start
// Build option: define CLKGEN_PERIOD_STROBE_EN to add period_stb.
// -----------------------------------------------------------------------------
module clk_gen_prog
   import clk_gen_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int DIV_RST  = 4,
   parameter int HIGH_RST = 2
) (
   input  logic             clk_source,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             clk_out,
   output logic             running
`ifdef CLKGEN_PERIOD_STROBE_EN
   ,
   output logic             period_stb
`endif
);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] div_a, high_a, div_next, high_next;
   logic [CNT_W-1:0] shadow_div, shadow_high;
   logic             wrap, apply, load, out_next;

   // Last cycle of the current period.
   assign wrap  = (state != IDLE) && (cnt == div_a - CNT_W'(1));
   // Active settings may change while idle or exactly at a period boundary.
   assign apply = (state == IDLE) || wrap;

   clk_gen_cfg_shadow #(
      .CNT_W (CNT_W)
   ) u_cfg (
      .clk_source  (clk_source),
      .rst         (rst),
      .cfg_div     (cfg_div),
      .cfg_high    (cfg_high),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .apply       (apply),
      .load        (load),
      .shadow_div  (shadow_div),
      .shadow_high (shadow_high)
   );

   assign div_next  = load ? shadow_div  : div_a;
   assign high_next = load ? shadow_high : high_a;

   always_ff @(posedge clk_source or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = '0;
      case (state)
         IDLE: begin
            if (en) begin
               state_next = RUN;
            end
         end
         RUN: begin
            cnt_next = wrap ? '0 : cnt + CNT_W'(1);
            if (!en) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            cnt_next = wrap ? '0 : cnt + CNT_W'(1);
            // A returning enable keeps the period going; otherwise stop only
            // once the final period is complete.
            if (en) begin
               state_next = RUN;
            end else if (wrap) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // Compare against the settings that will govern the next cycle so a new
      // period starts with its own high time.
      out_next = (state_next != IDLE) && (cnt_next < high_next);
   end

   always_ff @(posedge clk_source or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         div_a   <= CNT_W'(DIV_RST);
         high_a  <= CNT_W'(HIGH_RST);
         clk_out <= 1'b0;
         running <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         div_a   <= div_next;
         high_a  <= high_next;
         clk_out <= out_next;
         running <= (state_next != IDLE);
      end
   end

`ifdef CLKGEN_PERIOD_STROBE_EN
   always_ff @(posedge clk_source or posedge rst) begin
      if (rst) begin
         period_stb <= 1'b0;
      end else begin
         period_stb <= (state_next != IDLE) && (cnt_next == '0);
      end
   end
`endif

endmodule
